// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan driver:
// active-low segment patterns (g..a) and the packed digit/dp frame type.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = 2;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;
    typedef logic [NUM_DIGITS-1:0]              dp_t;

    typedef struct packed {
        digits_t digits;
        dp_t     dp;
    } frame_t;

    // Active-low one-hot anode pattern for the digit being scanned.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/seg_scan_driver_lut.sv
// BCD nibble to active-low seven-segment pattern (g..a); A-F show blank.
module seg_bcd_lut
    import seg_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-seg driver with tear-free double buffer.
// Optional leading-zero blanking: define SEG_SCAN_LEAD_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic                          pending,
    output logic                          frame_tick,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg
);

    localparam int                DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_t                active_q, active_d;
    frame_t                shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;

    frame_t                in_frame;
    logic                  term, wrap;
    logic [DIGIT_W-1:0]    sel_nib;
    logic                  sel_dp;
    logic [6:0]            lut_seg;
    logic                  sel_blank;

    assign in_frame = '{digits: digits_t'(digits_in), dp: dp_t'(dp_in)};
    assign term     = (div_cnt_q == DIV_LAST);
    assign wrap     = term && (idx_q == IDX_LAST);
    assign sel_nib  = active_q.digits[idx_q];
    assign sel_dp   = active_q.dp[idx_q];

    seg_bcd_lut u_lut (
        .nibble_i (sel_nib),
        .seg_o    (lut_seg)
    );

`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
    // Scan from the top digit down; a digit is blank while every digit at or
    // above it is zero. Invalid nibbles are nonzero and stop the blanking.
    logic [NUM_DIGITS-1:0] lz_blank;
    always_comb begin
        logic seen_nz;
        seen_nz  = 1'b0;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz     = seen_nz | (active_q.digits[i] != '0);
            lz_blank[i] = !seen_nz && (i != 0);
        end
    end
    assign sel_blank = lz_blank[idx_q];
`else
    assign sel_blank = 1'b0;
`endif

    always_comb begin
        div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
        idx_d     = term ? idx_q + 1'b1 : idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        // A load coinciding with the wrap bypasses the shadow entirely.
        if (wrap) begin
            if (load)
                active_d = in_frame;
            else if (pending_q)
                active_d = shadow_q;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = in_frame;
            pending_d = 1'b1;
        end

        an_d         = anode_sel(idx_q);
        seg_d        = {~sel_dp, sel_blank ? SEG_BLANK : lut_seg};
        frame_tick_d = (idx_q == '0) && (div_cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a cycle-count based display model.
module tb_seg_scan_driver;

    localparam int RD    = 4;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        pending, frame_tick;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(RD), .NUM_DIGITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .pending    (pending),
        .frame_tick (frame_tick),
        .an         (an),
        .seg        (seg)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [6:0] dec_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Model: cycles since reset release, displayed data, queued data.
    int          cyc = 0;
    logic [15:0] m_act_d = '0, m_shd_d = '0;
    logic [3:0]  m_act_dp = '0, m_shd_dp = '0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic        e_ft;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int d);
        logic [3:0] nib;
        logic [6:0] s7;
        nib = 4'((m_act_d >> (4 * d)) & 16'hF);
        s7  = (nib < 10) ? dec_tbl[nib] : 7'h7F;
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
        if (d > 0 && (m_act_d >> (4 * d)) == 16'h0) s7 = 7'h7F;
`endif
        return {~m_act_dp[d], s7};
    endfunction

    task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dp, input logic rn);
        int p, d;
        logic [3:0] one;
        one       = 4'b0001;
        load      = ld;
        digits_in = dg;
        dp_in     = dp;
        rst_n     = rn;
        @(posedge clk);
        if (!rn) begin
            cyc = 0; m_act_d = '0; m_act_dp = '0; m_shd_d = '0; m_shd_dp = '0; m_pend = 1'b0;
            e_an = 4'hF; e_seg = 8'hFF; e_ft = 1'b0;
        end else begin
            p     = cyc % FRAME;
            d     = p / RD;
            e_an  = ~(one << d);
            e_seg = exp_seg(d);
            e_ft  = (p == 0);
            if (p == FRAME - 1) begin
                if (ld) begin
                    m_act_d = dg; m_act_dp = dp;
                end else if (m_pend) begin
                    m_act_d = m_shd_d; m_act_dp = m_shd_dp;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_shd_d = dg; m_shd_dp = dp; m_pend = 1'b1;
            end
            cyc++;
        end
        @(negedge clk);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
    endtask

    // Advance until the next step lands on frame position p (bounded by one frame).
    task automatic idle_until(input int p);
        for (int i = 0; i < FRAME && (cyc % FRAME) != p; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
    endtask

    initial begin
        logic [15:0] dg;
        logic        ld, rn;

        step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 16'h0, 4'h0, 1'b0);
        idle(2 * FRAME + 3);

        idle_until(6);
        step(1'b1, 16'h1234, 4'b0100, 1'b1);
        idle(2 * FRAME);

        idle_until(3);
        step(1'b1, 16'h1111, 4'h0, 1'b1);
        idle(2);
        step(1'b1, 16'h5678, 4'h0, 1'b1);
        idle(2 * FRAME);

        idle_until(FRAME - 1);
        step(1'b1, 16'h9999, 4'h0, 1'b1);
        idle(FRAME + 2);

        idle_until(2);
        step(1'b1, 16'h00AF, 4'h0, 1'b1);
        idle(2 * FRAME);

        idle_until(2);
        step(1'b1, 16'h0000, 4'b0010, 1'b1);
        idle(2 * FRAME);

        idle_until(2 * RD + 1);
        step(1'b0, 16'h0, 4'h0, 1'b0);
        idle(FRAME + 4);

        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom % 6) == 0;
            dg = 16'($urandom);
            if ($urandom % 2) dg = dg & (16'hFFFF >> (4 * ($urandom % 4)));
            rn = ($urandom % 250) != 0;
            step(ld, dg, 4'($urandom), rn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
